// File: rtl/qspi_mem_responder.sv
// qspi_mem_responder: SPI/QSPI memory-device responder (RDID, RDSR, WREN, WRVECR, PP; READ with `QSPI_RESP_READ_EN)
module qspi_mem_responder #(
   parameter logic [7:0] JEDEC_ID      = 8'h20,
   parameter int         CLK_RATIO_MIN = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        C,
   input  logic        S,
   input  logic [3:0]  DQ_i,
   output logic [3:0]  DQ_o,
   output logic [3:0]  DQ_oe,
   output logic        wr_en,
   output logic [23:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        quad,
   output logic        wel,
   output logic        cmd_err
`ifdef QSPI_RESP_READ_EN
   ,
   output logic [23:0] rd_addr,
   input  logic [7:0]  rd_data
`endif
);
   typedef enum logic [2:0] {IDLE, OPCODE, ADDR, DATA_IN, DATA_OUT, IGNORE} state_t;
   localparam logic [7:0] OP_RDID = 8'h9F, OP_RDSR = 8'h05, OP_WREN = 8'h06;
   localparam logic [7:0] OP_WRVECR = 8'h61, OP_PP = 8'h02, OP_READ = 8'h03;
   // sync plus one cycle of output latency must fit in half a C period
   if (CLK_RATIO_MIN < 6) begin : g_ratio_chk
      $error("CLK_RATIO_MIN below 6 cannot meet the output timing");
   end
   state_t      state, state_n;
   logic [1:0]  c_s, s_s;
   logic [3:0]  dq_s1, dq_s2;
   logic        c_prev, s_prev, c_rise, c_fall, s_rise, s_fall;
   logic [4:0]  cnt, cnt_n, cnt_i;
   logic [7:0]  sr, sr_n, sh, op, op_n, n, n_n, tx, tx_n, cur, nxt_byte, vecr, vecr_n;
   logic [23:0] addr, addr_n, addr_sh;
   logic [2:0]  ocnt, ocnt_n;
   logic        extra, extra_n, vecr_ok, vecr_ok_n, is_read, supported;
   logic [3:0]  dq_o_n, dq_oe_n;
   logic        wr_en_n, quad_n, wel_n, cmd_err_n;
   logic [23:0] wr_addr_n;
   logic [7:0]  wr_data_n;
`ifdef QSPI_RESP_READ_EN
   logic [23:0] rd_addr_n;
   assign is_read  = 1'b1;
   assign nxt_byte = op == OP_RDID ? JEDEC_ID : op == OP_RDSR ? {6'b0, wel, 1'b0} : rd_data;
`else
   assign is_read  = 1'b0;
   assign nxt_byte = op == OP_RDID ? JEDEC_ID : op == OP_RDSR ? {6'b0, wel, 1'b0} : 8'h00;
`endif
   assign c_rise = c_s[1] & ~c_prev;
   assign c_fall = ~c_s[1] & c_prev;
   assign s_rise = s_s[1] & ~s_prev;
   assign s_fall = ~s_s[1] & s_prev;
   assign sh      = quad ? {sr[3:0], dq_s2} : {sr[6:0], dq_s2[0]};
   assign addr_sh = quad ? {addr[19:0], dq_s2} : {addr[22:0], dq_s2[0]};
   assign cnt_i   = cnt + (quad ? 5'd4 : 5'd1);
   assign cur     = ocnt == 3'd0 ? nxt_byte : tx;
   assign supported = sh == OP_RDID || sh == OP_RDSR || sh == OP_WREN || sh == OP_WRVECR
                      || sh == OP_PP || (is_read && sh == OP_READ);
   // synchronize pad inputs and keep previous values for edge detection
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         c_s    <= 2'b0;
         s_s    <= 2'b0;
         dq_s1  <= 4'b0;
         dq_s2  <= 4'b0;
         c_prev <= 1'b0;
         s_prev <= 1'b0;
      end else begin
         c_s    <= {c_s[0], C};
         s_s    <= {s_s[0], S};
         dq_s1  <= DQ_i;
         dq_s2  <= dq_s1;
         c_prev <= c_s[1];
         s_prev <= s_s[1];
      end
   end
   // next-state and output logic; a high chip select overrides any C edge
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      sr_n      = sr;
      op_n      = op;
      addr_n    = addr;
      n_n       = n;
      tx_n      = tx;
      ocnt_n    = ocnt;
      extra_n   = extra;
      vecr_n    = vecr;
      vecr_ok_n = vecr_ok;
      dq_o_n    = DQ_o;
      dq_oe_n   = DQ_oe;
      wr_en_n   = 1'b0;
      wr_addr_n = wr_addr;
      wr_data_n = wr_data;
      quad_n    = quad;
      wel_n     = wel;
      cmd_err_n = 1'b0;
`ifdef QSPI_RESP_READ_EN
      rd_addr_n = rd_addr;
`endif
      if (s_s[1]) begin
         state_n = IDLE;
         dq_o_n  = 4'b0;
         dq_oe_n = 4'b0;
         if (s_rise) begin
            if (state == IGNORE && op == OP_WREN && !extra) wel_n = 1'b1;
            if (op == OP_PP) wel_n = 1'b0;
            if (op == OP_WRVECR) begin
               wel_n = 1'b0;
               if (vecr_ok && wel) quad_n = ~vecr[7];
            end
         end
      end else if (state == IDLE) begin
         if (s_fall) begin
            state_n   = OPCODE;
            cnt_n     = 5'd0;
            sr_n      = 8'h00;
            op_n      = 8'h00;
            addr_n    = 24'h0;
            n_n       = 8'h00;
            tx_n      = 8'h00;
            ocnt_n    = 3'd0;
            extra_n   = 1'b0;
            vecr_ok_n = 1'b0;
         end
      end else if (c_rise) begin
         if (state == OPCODE) begin
            sr_n  = sh;
            cnt_n = cnt_i;
            if (cnt_i == 5'd8) begin
               cnt_n     = 5'd0;
               op_n      = sh;
               cmd_err_n = ~supported;
               state_n   = !supported ? IGNORE :
                           (sh == OP_RDID || sh == OP_RDSR) ? DATA_OUT :
                           sh == OP_WREN ? IGNORE : sh == OP_WRVECR ? DATA_IN : ADDR;
            end
         end else if (state == ADDR) begin
            addr_n = addr_sh;
            cnt_n  = cnt_i;
            if (cnt_i == 5'd24) begin
               cnt_n   = 5'd0;
               state_n = DATA_IN;
`ifdef QSPI_RESP_READ_EN
               if (op == OP_READ) begin
                  state_n   = DATA_OUT;
                  rd_addr_n = addr_sh;
               end
`endif
            end
         end else if (state == DATA_IN) begin
            sr_n  = sh;
            cnt_n = cnt_i;
            if (cnt_i == 5'd8) begin
               cnt_n = 5'd0;
               if (op == OP_WRVECR) begin
                  vecr_n    = sh;
                  vecr_ok_n = 1'b1;
                  state_n   = IGNORE;
               end else begin
                  n_n = n + 8'd1;
                  if (wel) begin
                     wr_en_n   = 1'b1;
                     wr_addr_n = {addr[23:8], addr[7:0] + n};
                     wr_data_n = sh;
                  end
               end
            end
         end else if (state == IGNORE) begin
            extra_n = 1'b1;
         end
      end else if (c_fall && state == DATA_OUT) begin
         dq_o_n  = quad ? cur[7:4] : {2'b0, cur[7], 1'b0};
         dq_oe_n = quad ? 4'hF : 4'h2;
         tx_n    = quad ? {cur[3:0], 4'h0} : {cur[6:0], 1'b0};
         ocnt_n  = ocnt + (quad ? 3'd4 : 3'd1);
`ifdef QSPI_RESP_READ_EN
         if (op == OP_READ && ocnt == 3'd0) rd_addr_n = rd_addr + 24'd1;
`endif
      end
   end
   // state and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         cnt     <= 5'd0;
         sr      <= 8'h00;
         op      <= 8'h00;
         addr    <= 24'h0;
         n       <= 8'h00;
         tx      <= 8'h00;
         ocnt    <= 3'd0;
         extra   <= 1'b0;
         vecr    <= 8'h00;
         vecr_ok <= 1'b0;
         DQ_o    <= 4'b0;
         DQ_oe   <= 4'b0;
         wr_en   <= 1'b0;
         wr_addr <= 24'h0;
         wr_data <= 8'h00;
         quad    <= 1'b0;
         wel     <= 1'b0;
         cmd_err <= 1'b0;
`ifdef QSPI_RESP_READ_EN
         rd_addr <= 24'h0;
`endif
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         sr      <= sr_n;
         op      <= op_n;
         addr    <= addr_n;
         n       <= n_n;
         tx      <= tx_n;
         ocnt    <= ocnt_n;
         extra   <= extra_n;
         vecr    <= vecr_n;
         vecr_ok <= vecr_ok_n;
         DQ_o    <= dq_o_n;
         DQ_oe   <= dq_oe_n;
         wr_en   <= wr_en_n;
         wr_addr <= wr_addr_n;
         wr_data <= wr_data_n;
         quad    <= quad_n;
         wel     <= wel_n;
         cmd_err <= cmd_err_n;
`ifdef QSPI_RESP_READ_EN
         rd_addr <= rd_addr_n;
`endif
      end
   end
endmodule

// File: tb/tb_qspi_mem_responder.sv
// tb_qspi_mem_responder: directed bench with a write scoreboard for qspi_mem_responder
module tb_qspi_mem_responder;
   logic        clk = 1'b0, reset_n = 1'b0, C = 1'b0, S = 1'b1;
   logic [3:0]  DQ_i = 4'b0, DQ_o, DQ_oe;
   logic        wr_en, quad, wel, cmd_err;
   logic [23:0] wr_addr;
   logic [7:0]  wr_data;
   int          tests = 0, fails = 0, wr_cnt = 0, err_cnt = 0;
   logic        q = 1'b0;
   logic [31:0] sb[$];
   logic [31:0] exp_w;
   logic [7:0]  b;
   logic [3:0]  oe;
`ifdef QSPI_RESP_READ_EN
   logic [23:0] rd_addr;
   logic [7:0]  rd_data = 8'h00;
   // backing memory: data is a function of address, one cycle latency
   always @(posedge clk) rd_data <= rd_addr[7:0] + rd_addr[23:16] + 8'd1;
`endif

   qspi_mem_responder dut (
      .clk(clk), .reset_n(reset_n), .C(C), .S(S), .DQ_i(DQ_i), .DQ_o(DQ_o), .DQ_oe(DQ_oe),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .quad(quad), .wel(wel), .cmd_err(cmd_err)
`ifdef QSPI_RESP_READ_EN
      , .rd_addr(rd_addr), .rd_data(rd_data)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // every write strobe must match the oldest expected write
   always @(negedge clk) begin
      if (cmd_err) err_cnt++;
      if (wr_en) begin
         wr_cnt++;
         if (sb.size() == 0) chk("wr_spurious", {8'h00, wr_addr}, 32'hFFFFFFFF);
         else begin
            exp_w = sb.pop_front();
            chk("wr_addr_data", {wr_addr, wr_data}, exp_w);
         end
      end
   end

   task automatic clk_c(input logic [3:0] din, output logic [3:0] dout, output logic [3:0] doe);
      DQ_i = din;
      #50;
      dout = DQ_o;
      doe  = DQ_oe;
      C = 1'b1;
      #50;
      C = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] v);
      logic [3:0] d, e;
      if (q) begin
         clk_c(v[7:4], d, e);
         clk_c(v[3:0], d, e);
      end else
         for (int i = 7; i >= 0; i--) clk_c({3'b0, v[i]}, d, e);
   endtask

   task automatic recv_byte(output logic [7:0] v, output logic [3:0] doe);
      logic [3:0] d;
      v = 8'h00;
      if (q) begin
         clk_c(4'h0, d, doe);
         v[7:4] = d;
         clk_c(4'h0, d, doe);
         v[3:0] = d;
      end else
         for (int i = 7; i >= 0; i--) begin
            clk_c(4'h0, d, doe);
            v[i] = d[1];
         end
   endtask

   task automatic cs_lo();
      S = 1'b0;
      #50;
   endtask

   task automatic cs_hi();
      #50;
      S = 1'b1;
      #100;
   endtask

   task automatic cmd(input logic [7:0] op);
      cs_lo();
      send_byte(op);
      cs_hi();
   endtask

   initial begin
      logic [3:0] d, e;
      #32;
      chk("rst_quad", quad, 0);
      chk("rst_wel", wel, 0);
      chk("rst_oe", DQ_oe, 0);
      chk("rst_dqo", DQ_o, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_cmd_err", cmd_err, 0);
      reset_n = 1'b1;
      #20;
      // single-mode RDID, two bytes
      cs_lo();
      send_byte(8'h9F);
      recv_byte(b, oe);
      chk("rdid_b0", b, 8'h20);
      chk("rdid_oe0", oe, 4'b0010);
      recv_byte(b, oe);
      chk("rdid_b1", b, 8'h20);
      chk("rdid_oe1", oe, 4'b0010);
      cs_hi();
      chk("rdid_oe_off", DQ_oe, 0);
      chk("rdid_no_err", err_cnt, 0);
      // WREN sets wel, visible through RDSR
      cmd(8'h06);
      chk("wren_wel", wel, 1);
      cs_lo();
      send_byte(8'h05);
      recv_byte(b, oe);
      chk("rdsr_single", b, 8'h02);
      cs_hi();
      // single PP at page end: two full bytes wrap, a 3-bit partial byte is dropped
      cs_lo();
      send_byte(8'h02);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'hFE);
      sb.push_back({24'h0000FE, 8'hAA});
      send_byte(8'hAA);
      sb.push_back({24'h0000FF, 8'h55});
      send_byte(8'h55);
      for (int i = 0; i < 3; i++) clk_c(4'h1, d, e);
      cs_hi();
      chk("pp_partial_cnt", wr_cnt, 2);
      chk("pp_wel_clr", wel, 0);
      // WREN with a ninth bit does not set wel
      cs_lo();
      send_byte(8'h06);
      clk_c(4'h0, d, e);
      cs_hi();
      chk("wren_9bit", wel, 0);
      // enter quad mode through WRVECR
      cmd(8'h06);
      chk("wren2_wel", wel, 1);
      cs_lo();
      send_byte(8'h61);
      send_byte(8'h4F);
      cs_hi();
      chk("vecr_wel", wel, 0);
      chk("vecr_quad", quad, 1);
      q = 1'b1;
      cs_lo();
      send_byte(8'h05);
      recv_byte(b, oe);
      chk("rdsr_quad", b, 8'h00);
      chk("rdsr_quad_oe", oe, 4'hF);
      cs_hi();
      // quad PP of 20 bytes wrapping within the page
      cmd(8'h06);
      cs_lo();
      send_byte(8'h02);
      send_byte(8'hA3); send_byte(8'h00); send_byte(8'hF0);
      for (int i = 0; i < 20; i++) begin
         exp_w = {16'hA300, 8'hF0 + 8'(i), 8'(i + 1)};
         sb.push_back(exp_w);
         send_byte(8'(i + 1));
      end
      cs_hi();
      chk("pp20_cnt", wr_cnt, 22);
      chk("pp20_wel", wel, 0);
      // PP without WREN writes nothing
      cs_lo();
      send_byte(8'h02);
      send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
      for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i));
      cs_hi();
      chk("pp_nowel_cnt", wr_cnt, 22);
      // unsupported opcode: one error pulse, lines not driven
      cs_lo();
      send_byte(8'hAB);
      recv_byte(b, oe);
      chk("bad_op_oe", oe, 0);
      cs_hi();
      chk("bad_op_err", err_cnt, 1);
`ifdef QSPI_RESP_READ_EN
      cs_lo();
      send_byte(8'h03);
      send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
      recv_byte(b, oe);
      chk("read_b0", b, 8'hFF);
      chk("read_oe", oe, 4'hF);
      recv_byte(b, oe);
      chk("read_b1", b, 8'h01);
      cs_hi();
      chk("read_no_err", err_cnt, 1);
`else
      cmd(8'h03);
      chk("read_absent_err", err_cnt, 2);
`endif
      // reset in the middle of a PP data byte
      cmd(8'h06);
      cs_lo();
      send_byte(8'h02);
      send_byte(8'hA3); send_byte(8'h00); send_byte(8'h10);
      clk_c(4'h7, d, e);
      reset_n = 1'b0;
      #30;
      chk("mid_rst_quad", quad, 0);
      chk("mid_rst_wel", wel, 0);
      chk("mid_rst_oe", DQ_oe, 0);
      reset_n = 1'b1;
      #20;
      q = 1'b0;
      cs_hi();
      chk("mid_rst_wr_cnt", wr_cnt, 22);
      cs_lo();
      send_byte(8'h9F);
      recv_byte(b, oe);
      chk("post_rst_rdid", b, 8'h20);
      cs_hi();
      chk("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
